wavetable_voice_mixer: RTL and testbench
========================================

Name: wavetable_voice_mixer

Overview:
- Parametrised, multi-voice successor to the single-note sine decoder.
- Time-multiplexes VOICES note inputs over one shared pitch-table read port and one dual-read wave memory.
- Per voice: keeps a fractional phase accumulator, linearly interpolates between adjacent wave samples, and sums all voices into one mixed sample per sample_tick.
- Sits between the note/sequencer logic and the audio output stage.

Parameters:
- VOICES, 4, number of voices; must be ≥1.
- IDX_W, 5, pitch-table index width, taken from note[IDX_W-1:0].
- NOTE_W, 10, per-voice note word width; bit NOTE_W-1 is gate.
- ADDR_W, 16, wave memory address, table offset and table length width.
- FRAC_W, 8, phase fraction bits.
- AMP_W, 8, unsigned wave sample width.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- notes  in  VOICES*NOTE_W  voice v = notes[v*NOTE_W +: NOTE_W].
- sample_tick  in  1  one-cycle pulse; starts a mixing frame.
- tbl_addr  out  IDX_W  pitch-table address; the table is sync-read with 1-cycle latency.
- tbl_data  in  2*ADDR_W+ADDR_W+FRAC_W  packed {offset, length, step}. step is an unsigned fixed-point value, ADDR_W integer bits and FRAC_W fraction bits.
- wave_addr_a, wave_addr_b  out  ADDR_W each  wave read addresses; sync-read with 1-cycle latency.
- wave_data_a, wave_data_b  in  AMP_W each  wave samples.
- mix_out  out  AMP_W+clog2(VOICES)  mixed sample; held between frames.
- mix_valid  out  1  one-cycle pulse when mix_out updates.
- overrun  out  1  one-cycle pulse when sample_tick arrives while busy.

Behaviour:
- Reset state:
  - mix_out=0, mix_valid=0, overrun=0, tbl_addr=0, wave_addr_a/b=0.
  - All per-voice phases (pos, frac) = 0; last-index registers = 0.
  - FSM goes to IDLE.
- Reset asserted mid-frame aborts the frame with no mix_valid.
- FSM states: IDLE, TBL, WAVE, INTERP, DONE. The voice counter v runs 0..VOICES-1.
- IDLE:
  - On sample_tick go to TBL with v=0 and accumulator=0.
  - Also latch all notes into a snapshot register, so notes are stable for the whole frame.
- TBL (1 cycle): drive tbl_addr = idx(v).
- WAVE (1 cycle):
  - tbl_data is valid; register offset, length, step.
  - Drive wave_addr_a = offset+pos.
  - Drive wave_addr_b = offset + (pos+1==length ? 0 : pos+1). All additions are modulo 2^ADDR_W.
- INTERP (1 cycle), with wave data valid:
  - s = a + (((b-a) * frac) >>> FRAC_W). The difference is signed AMP_W+1; the product is signed; s lies in [min(a,b), max(a,b)].
  - Voice is active if gate=1 and length≠0. If active, add s to the accumulator; otherwise add 0.
  - Phase update, active voices only: {carry, frac'} = frac + step_frac; p = pos + step_int + carry; pos' = (p ≥ length) ? p - length : p.
  - Steps with step_int ≥ length are unsupported; wrap is applied once only.
  - Inactive voice: pos=0, frac=0.
  - If v=VOICES-1 go to DONE; else v++ and go to TBL.
- Retrigger: in WAVE, if a voice's snapshot idx ≠ its last-index register, or its gate rose since the last frame, use pos=0 and frac=0 for that voice. Then update the last-index and last-gate registers.
- DONE (1 cycle): mix_out ← accumulator; mix_valid=1; go to IDLE.
- Latency: mix_valid asserts exactly 3*VOICES+2 cycles after the sample_tick cycle.
- Busy means not in IDLE. A sample_tick while busy is ignored and pulses overrun the next cycle. A tick in the same cycle as DONE is also an overrun.
- The accumulator never overflows: its width is AMP_W+clog2(VOICES). For VOICES=1 the width is AMP_W.

Test Plan:
- Reset then idle: mix_out=0, mix_valid=0 with no ticks. Assert rst mid-frame → no mix_valid, and all phases read back 0 on the next frame.
- VOICES=1, gate=1, wave table ramp 0,16,32,… with offset=0x100, length=16, step=0x0080 (0.5):
  - Successive frames give 0, 8, 16, 24.
  - wave_addr_a goes 0x100, 0x100, 0x101.
  - mix_valid comes 5 cycles after each tick.
- Wrap: length=4, step=0x0100, table {10,20,30,40} → frames 10,20,30,40,10. At pos=3, wave_addr_b=offset+0.
- Mix of 4 voices with constant tables 255 and all gates on → mix_out=1020, mix_valid 14 cycles after the tick. Clear gate on voice 2 → 765. Setting length=0 on a gated voice → that voice contributes 0.
- Retrigger: mid-run, change voice 0 idx 3→5 → the next frame samples pos=0 of table 5. Unchanged voices keep their phase continuity.
- Overrun: tick, then another tick 3 cycles later → overrun pulses once, a single mix_valid occurs, and the phase advances by exactly one step.

Source files
------------

// File: rtl/wavetable_voice_mixer.sv
// Multi-voice wavetable mixer: each voice fetches its pitch-table entry, reads two
// adjacent wave samples, interpolates linearly and is summed into one sample per tick.
module wavetable_voice_mixer #(
    parameter int VOICES = 4,
    parameter int IDX_W  = 5,
    parameter int NOTE_W = 10,
    parameter int ADDR_W = 16,
    parameter int FRAC_W = 8,
    parameter int AMP_W  = 8,
    localparam int MIX_W  = AMP_W + $clog2(VOICES),
    localparam int STEP_W = ADDR_W + FRAC_W,
    localparam int TBL_W  = 2 * ADDR_W + STEP_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [VOICES*NOTE_W-1:0] notes,
    input  logic                     sample_tick,
    output logic [IDX_W-1:0]         tbl_addr,
    input  logic [TBL_W-1:0]         tbl_data,
    output logic [ADDR_W-1:0]        wave_addr_a,
    output logic [ADDR_W-1:0]        wave_addr_b,
    input  logic [AMP_W-1:0]         wave_data_a,
    input  logic [AMP_W-1:0]         wave_data_b,
    output logic [MIX_W-1:0]         mix_out,
    output logic                     mix_valid,
    output logic                     overrun,
    output logic [2:0]               dbg_state
);
    localparam int VW = (VOICES > 1) ? $clog2(VOICES) : 1;
    localparam int PW = AMP_W + FRAC_W + 2;

    typedef enum logic [2:0] {S_IDLE, S_TBL, S_WAVE, S_INTERP, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [VW-1:0]       v_q, v_d;
    logic [MIX_W-1:0]    acc_q, acc_d;
    logic [MIX_W-1:0]    mix_out_q;
    logic                mix_valid_q, overrun_q;
    logic [ADDR_W-1:0]   len_q;
    logic [STEP_W-1:0]   step_q;

    logic [IDX_W-1:0]    snap_idx_q  [VOICES];
    logic                snap_gate_q [VOICES];
    logic [IDX_W-1:0]    last_idx_q  [VOICES];
    logic                last_gate_q [VOICES];
    logic [ADDR_W-1:0]   pos_q       [VOICES];
    logic [FRAC_W-1:0]   frac_q      [VOICES];

    // Only idx and gate bits of each note word are meaningful.
    logic unused_notes;
    assign unused_notes = ^notes;

    logic [ADDR_W-1:0] tbl_offset, tbl_length;
    logic [STEP_W-1:0] tbl_step;
    assign tbl_offset = tbl_data[TBL_W-1 -: ADDR_W];
    assign tbl_length = tbl_data[STEP_W +: ADDR_W];
    assign tbl_step   = tbl_data[STEP_W-1:0];

    logic              retrig;
    logic [ADDR_W-1:0] pos_eff, pos_inc, pos_next;
    assign retrig   = (snap_idx_q[v_q] != last_idx_q[v_q]) || (snap_gate_q[v_q] && !last_gate_q[v_q]);
    assign pos_eff  = retrig ? '0 : pos_q[v_q];
    assign pos_inc  = pos_eff + ADDR_W'(1);
    assign pos_next = (pos_inc == tbl_length) ? '0 : pos_inc;

    // Signed interpolation: floor of (b-a)*frac / 2^FRAC_W keeps s between a and b.
    logic signed [AMP_W:0]  diff;
    logic signed [PW-1:0]   prod, a_ext;
    logic [AMP_W-1:0]       interp_s;
    assign diff     = $signed({1'b0, wave_data_b}) - $signed({1'b0, wave_data_a});
    assign prod     = PW'(diff) * PW'($signed({1'b0, frac_q[v_q]}));
    assign a_ext    = {{(PW-AMP_W){1'b0}}, wave_data_a};
    assign interp_s = AMP_W'(a_ext + (prod >>> FRAC_W));

    logic              active;
    logic [FRAC_W:0]   frac_sum;
    logic [ADDR_W:0]   phase_sum;
    logic [ADDR_W-1:0] pos_new;
    assign active    = snap_gate_q[v_q] && (len_q != '0);
    assign frac_sum  = {1'b0, frac_q[v_q]} + {1'b0, step_q[FRAC_W-1:0]};
    assign phase_sum = {1'b0, pos_q[v_q]} + {1'b0, step_q[STEP_W-1:FRAC_W]}
                     + (ADDR_W+1)'(frac_sum[FRAC_W]);
    assign pos_new   = (phase_sum >= {1'b0, len_q}) ? ADDR_W'(phase_sum - {1'b0, len_q})
                                                    : phase_sum[ADDR_W-1:0];

    always_comb begin
        state_d     = state_q;
        v_d         = v_q;
        acc_d       = acc_q;
        tbl_addr    = '0;
        wave_addr_a = '0;
        wave_addr_b = '0;
        case (state_q)
            S_IDLE: begin
                if (sample_tick) begin
                    state_d = S_TBL;
                    v_d     = '0;
                    acc_d   = '0;
                end
            end
            S_TBL: begin
                tbl_addr = snap_idx_q[v_q];
                state_d  = S_WAVE;
            end
            S_WAVE: begin
                wave_addr_a = tbl_offset + pos_eff;
                wave_addr_b = tbl_offset + pos_next;
                state_d     = S_INTERP;
            end
            S_INTERP: begin
                if (active) acc_d = acc_q + MIX_W'(interp_s);
                if (v_q == VW'(VOICES - 1)) begin
                    state_d = S_DONE;
                end else begin
                    v_d     = v_q + VW'(1);
                    state_d = S_TBL;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            v_q         <= '0;
            acc_q       <= '0;
            mix_out_q   <= '0;
            mix_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
            len_q       <= '0;
            step_q      <= '0;
            for (int i = 0; i < VOICES; i++) begin
                snap_idx_q[i]  <= '0;
                snap_gate_q[i] <= 1'b0;
                last_idx_q[i]  <= '0;
                last_gate_q[i] <= 1'b0;
                pos_q[i]       <= '0;
                frac_q[i]      <= '0;
            end
        end else begin
            state_q     <= state_d;
            v_q         <= v_d;
            acc_q       <= acc_d;
            mix_valid_q <= (state_q == S_DONE);
            overrun_q   <= sample_tick && (state_q != S_IDLE);
            if (state_q == S_DONE) mix_out_q <= acc_q;
            if (state_q == S_IDLE && sample_tick) begin
                for (int i = 0; i < VOICES; i++) begin
                    snap_idx_q[i]  <= notes[i*NOTE_W +: IDX_W];
                    snap_gate_q[i] <= notes[i*NOTE_W + NOTE_W - 1];
                end
            end
            if (state_q == S_WAVE) begin
                len_q            <= tbl_length;
                step_q           <= tbl_step;
                last_idx_q[v_q]  <= snap_idx_q[v_q];
                last_gate_q[v_q] <= snap_gate_q[v_q];
                if (retrig) begin
                    pos_q[v_q]  <= '0;
                    frac_q[v_q] <= '0;
                end
            end
            if (state_q == S_INTERP) begin
                pos_q[v_q]  <= active ? pos_new : '0;
                frac_q[v_q] <= active ? frac_sum[FRAC_W-1:0] : '0;
            end
        end
    end

    // mix_valid and overrun are single-cycle pulses with no back-pressure; mix_out holds.
    assign mix_out   = mix_out_q;
    assign mix_valid = mix_valid_q;
    assign overrun   = overrun_q;
    assign dbg_state = state_q;
endmodule

// File: tb/tb_wavetable_voice_mixer.sv
// Bench for wavetable_voice_mixer: a 4-voice and a 1-voice instance share table memories;
// a frame-level model predicts every output cycle, directed frames pin literal values.
module tb_wavetable_voice_mixer;
    logic clk;
    logic rst;
    logic tick4, tick1;
    logic [39:0] notes4;
    logic [9:0]  notes1;

    logic [4:0]  tbl_addr4, tbl_addr1;
    logic [55:0] tbl_data4, tbl_data1;
    logic [15:0] wa4, wb4, wa1, wb1;
    logic [7:0]  wda4, wdb4, wda1, wdb1;
    logic [9:0]  mix_out4;
    logic [7:0]  mix_out1;
    logic        mix_valid4, mix_valid1, overrun4, overrun1;
    logic [2:0]  dbg4, dbg1;

    logic [55:0] tbl_mem  [0:31];
    logic [7:0]  wave_mem [0:65535];

    int n_cmp = 0;
    int n_fail = 0;
    bit cmp_en = 0;

    wavetable_voice_mixer #(.VOICES(4)) u_dut4 (
        .clk(clk), .rst(rst), .notes(notes4), .sample_tick(tick4),
        .tbl_addr(tbl_addr4), .tbl_data(tbl_data4),
        .wave_addr_a(wa4), .wave_addr_b(wb4), .wave_data_a(wda4), .wave_data_b(wdb4),
        .mix_out(mix_out4), .mix_valid(mix_valid4), .overrun(overrun4), .dbg_state(dbg4)
    );

    wavetable_voice_mixer #(.VOICES(1)) u_dut1 (
        .clk(clk), .rst(rst), .notes(notes1), .sample_tick(tick1),
        .tbl_addr(tbl_addr1), .tbl_data(tbl_data1),
        .wave_addr_a(wa1), .wave_addr_b(wb1), .wave_data_a(wda1), .wave_data_b(wdb1),
        .mix_out(mix_out1), .mix_valid(mix_valid1), .overrun(overrun1), .dbg_state(dbg1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Synchronous-read memories, one cycle of latency.
    always @(posedge clk) begin
        tbl_data4 <= tbl_mem[tbl_addr4];
        tbl_data1 <= tbl_mem[tbl_addr1];
        wda4 <= wave_mem[wa4];
        wdb4 <= wave_mem[wb4];
        wda1 <= wave_mem[wa1];
        wdb1 <= wave_mem[wb1];
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- frame-level model ----------------
    int mpos  [2][4];
    int mfrac [2][4];
    int mlidx [2][4];
    bit mlgate[2][4];

    function automatic void model_clear();
        for (int k = 0; k < 2; k++)
            for (int v = 0; v < 4; v++) begin
                mpos[k][v] = 0; mfrac[k][v] = 0; mlidx[k][v] = 0; mlgate[k][v] = 0;
            end
    endfunction

    function automatic int model_frame(input int k, input int nv, input logic [39:0] nts);
        int sum, idx, off, len, sint, sfr, pos, nxt, a, b, s, t, p;
        bit gate;
        logic [55:0] ent;
        sum = 0;
        for (int v = 0; v < nv; v++) begin
            idx  = int'(nts[v*10 +: 5]);
            gate = nts[v*10 + 9];
            ent  = tbl_mem[idx];
            off  = int'(ent[55:40]);
            len  = int'(ent[39:24]);
            sint = int'(ent[23:8]);
            sfr  = int'(ent[7:0]);
            if (idx != mlidx[k][v] || (gate && !mlgate[k][v])) begin
                mpos[k][v] = 0; mfrac[k][v] = 0;
            end
            mlidx[k][v] = idx;
            mlgate[k][v] = gate;
            pos = mpos[k][v];
            nxt = (pos + 1) % 65536;
            if (nxt == len) nxt = 0;
            a = int'(wave_mem[(off + pos) % 65536]);
            b = int'(wave_mem[(off + nxt) % 65536]);
            if (gate && len != 0) begin
                s = a + (((b - a) * mfrac[k][v]) >>> 8);
                sum += s;
                t = mfrac[k][v] + sfr;
                p = pos + sint + t / 256;
                if (p >= len) p -= len;
                mpos[k][v] = p;
                mfrac[k][v] = t % 256;
            end else begin
                mpos[k][v] = 0; mfrac[k][v] = 0;
            end
        end
        return sum;
    endfunction

    int m_busy[2], m_pend[2], m_mix[2];
    bit m_valid[2], m_ovr[2];
    logic [1:0] ticks;
    assign ticks = {tick1, tick4};

    // Frame takes 3*nv+1 busy cycles after the tick cycle; result is visible one cycle later.
    always @(posedge clk) begin
        if (rst) begin
            model_clear();
            for (int k = 0; k < 2; k++) begin
                m_busy[k] <= 0; m_pend[k] <= 0; m_mix[k] <= 0;
                m_valid[k] <= 0; m_ovr[k] <= 0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                m_ovr[k]   <= ticks[k] && (m_busy[k] != 0);
                m_valid[k] <= (m_busy[k] == 1);
                if (m_busy[k] == 1) m_mix[k] <= m_pend[k];
                if (m_busy[k] != 0) begin
                    m_busy[k] <= m_busy[k] - 1;
                end else if (ticks[k]) begin
                    m_busy[k] <= (k == 0) ? 13 : 4;
                    m_pend[k] <= model_frame(k, (k == 0) ? 4 : 1, (k == 0) ? notes4 : {30'd0, notes1});
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("mix_valid4", int'(mix_valid4), int'(m_valid[0]));
            check("mix_out4",   int'(mix_out4),   m_mix[0]);
            check("overrun4",   int'(overrun4),   int'(m_ovr[0]));
            check("mix_valid1", int'(mix_valid1), int'(m_valid[1]));
            check("mix_out1",   int'(mix_out1),   m_mix[1]);
            check("overrun1",   int'(overrun1),   int'(m_ovr[1]));
        end
    end

    // ---------------- driver tasks ----------------
    function automatic logic [9:0] nw(input bit g, input int idx);
        return {g, 4'b0000, 5'(idx)};
    endfunction

    task automatic run_frame(input int k, output int lat, output int wa, output int wb);
        lat = 0; wa = -1; wb = -1;
        @(negedge clk);
        if (k == 0) tick4 = 1'b1; else tick1 = 1'b1;
        @(negedge clk);
        tick4 = 1'b0; tick1 = 1'b0;
        lat = 1;
        while (!((k == 0) ? mix_valid4 : mix_valid1) && lat < 60) begin
            if (lat == 2 && k == 1) begin
                wa = int'(wa1); wb = int'(wb1);
            end
            @(negedge clk);
            lat++;
        end
    endtask

    int lat, cwa, cwb, n_ov, n_v, last_mix;
    int exp_ramp[4] = '{0, 8, 16, 24};
    int exp_ramp_a[3] = '{'h100, 'h100, 'h101};
    int exp_wrap[5] = '{10, 20, 30, 40, 10};

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; tick4 = 1'b0; tick1 = 1'b0; notes4 = '0; notes1 = '0;
        for (int i = 0; i < 65536; i++) wave_mem[i] = 8'd0;
        for (int i = 0; i < 32; i++) tbl_mem[i] = '0;
        for (int i = 0; i < 16; i++) wave_mem['h100 + i] = 8'(16 * i);
        wave_mem['h200] = 10; wave_mem['h201] = 20; wave_mem['h202] = 30; wave_mem['h203] = 40;
        for (int i = 0; i < 8; i++) wave_mem['h300 + i] = 8'd255;
        for (int i = 0; i < 8; i++) wave_mem['h400 + i] = 8'(7 + 3 * i);
        tbl_mem[1] = {16'h0100, 16'd16, 24'h000080};
        tbl_mem[2] = {16'h0200, 16'd4,  24'h000100};
        tbl_mem[3] = {16'h0300, 16'd8,  24'h000100};
        tbl_mem[4] = {16'h0300, 16'd0,  24'h000100};
        tbl_mem[5] = {16'h0400, 16'd8,  24'h000100};

        repeat (2) @(negedge clk);
        cmp_en = 1'b1;
        rst = 1'b0;
        repeat (6) @(negedge clk);
        check("idle_mix_out4", int'(mix_out4), 0);
        check("idle_mix_valid4", int'(mix_valid4), 0);
        check("idle_mix_out1", int'(mix_out1), 0);
        check("idle_mix_valid1", int'(mix_valid1), 0);

        // Single voice ramp, half-sample step
        notes1 = nw(1, 1);
        for (int i = 0; i < 4; i++) begin
            run_frame(1, lat, cwa, cwb);
            check("ramp_latency", lat, 5);
            check("ramp_mix", int'(mix_out1), exp_ramp[i]);
            if (i < 3) check("ramp_wave_addr_a", cwa, exp_ramp_a[i]);
        end

        // Wrap on a 4-entry table
        notes1 = nw(1, 2);
        for (int i = 0; i < 5; i++) begin
            run_frame(1, lat, cwa, cwb);
            check("wrap_latency", lat, 5);
            check("wrap_mix", int'(mix_out1), exp_wrap[i]);
            if (i == 3) begin
                check("wrap_wave_addr_a", cwa, 'h203);
                check("wrap_wave_addr_b", cwb, 'h200);
            end
        end

        // Four constant voices
        notes4 = {nw(1, 3), nw(1, 3), nw(1, 3), nw(1, 3)};
        run_frame(0, lat, cwa, cwb);
        check("mix4_latency", lat, 14);
        check("mix4_full", int'(mix_out4), 1020);
        notes4 = {nw(1, 3), nw(0, 3), nw(1, 3), nw(1, 3)};
        run_frame(0, lat, cwa, cwb);
        check("mix4_gate_off", int'(mix_out4), 765);
        notes4 = {nw(1, 4), nw(1, 3), nw(1, 3), nw(1, 3)};
        run_frame(0, lat, cwa, cwb);
        check("mix4_len_zero", int'(mix_out4), 765);

        // Retrigger on voice 0 while voice 1 keeps its ramp phase
        notes4 = {nw(0, 0), nw(0, 0), nw(1, 1), nw(1, 3)};
        run_frame(0, lat, cwa, cwb);
        check("retrig_f1", int'(mix_out4), 255);
        run_frame(0, lat, cwa, cwb);
        check("retrig_f2", int'(mix_out4), 263);
        run_frame(0, lat, cwa, cwb);
        check("retrig_f3", int'(mix_out4), 271);
        notes4 = {nw(0, 0), nw(0, 0), nw(1, 1), nw(1, 5)};
        run_frame(0, lat, cwa, cwb);
        check("retrig_f4", int'(mix_out4), 31);

        // Second tick three cycles into a frame
        n_ov = 0; n_v = 0; last_mix = -1;
        @(negedge clk);
        tick4 = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            tick4 = (c == 3);
            if (overrun4) n_ov++;
            if (mix_valid4) begin
                n_v++;
                last_mix = int'(mix_out4);
            end
        end
        check("overrun_pulses", n_ov, 1);
        check("overrun_valids", n_v, 1);
        check("overrun_mix", last_mix, 42);
        run_frame(0, lat, cwa, cwb);
        check("after_overrun_mix", int'(mix_out4), 53);

        // Reset in the middle of a frame
        @(negedge clk);
        tick4 = 1'b1;
        @(negedge clk);
        tick4 = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_v = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (mix_valid4) n_v++;
        end
        check("abort_valids", n_v, 0);
        check("abort_mix_out", int'(mix_out4), 0);
        run_frame(0, lat, cwa, cwb);
        check("post_reset_latency", lat, 14);
        check("post_reset_mix", int'(mix_out4), 7);

        repeat (3) @(negedge clk);
        cmp_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end
endmodule
